uart_imem_loader: RTL

//  Writer side of the instruction-memory port: the core only reads instruction memory through the
//  8-bit word address; this block fills it at boot.

---
 rtl/loader_pkg.sv | 36 +++
 rtl/uart_rx_byte.sv | 95 +++++++++
 rtl/uart_imem_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader:
// frame FSM / receiver state encodings and bit-timer sizing helpers.
package loader_pkg;

   typedef enum logic [2:0] {
      S_SYNC = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   function automatic int bit_cnt_of(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic int half_cnt_of(input int bit_cnt);
      return bit_cnt / 2;
   endfunction

   // Width of a counter that must hold values 0 .. n-1.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling timer,
// LSB-first shift register, one-cycle rx_valid / rx_ferr pulses.
module uart_rx_byte
   import loader_pkg::*;
#(
   parameter int BIT_CNT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       rx_ferr
);

   localparam int CNT_W = cnt_width(BIT_CNT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_cnt_of(BIT_CNT) - 1);

   rx_state_e        state_q, state_d;
   logic [2:0]       sync_q, sync_d;   // [1:0] synchronizer, [2] previous sample
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       sh_q, sh_d;
   logic             rx_s, fall_s;

   assign rx_s    = sync_q[1];
   assign fall_s  = sync_q[2] & ~sync_q[1];
   assign rx_byte = sh_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RX_IDLE;
         sync_q  <= 3'b111;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         sh_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
      end
   end

   always_comb begin
      sync_d   = {sync_q[1:0], uart_rx};
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      bit_d    = bit_q;
      sh_d     = sh_q;
      rx_valid = 1'b0;
      rx_ferr  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (fall_s) state_d = RX_START;
            else        state_d = RX_IDLE;
         end
         RX_START: begin
            // Mid start bit: a high line here was only a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               state_d = RX_START;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               sh_d    = {rx_s, sh_q[7:1]};
               bit_d   = bit_q + 3'd1;
               state_d = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
            end else begin
               state_d = RX_DATA;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d    = '0;
               rx_valid = rx_s;
               rx_ferr  = ~rx_s;
               state_d  = RX_IDLE;
            end else begin
               state_d = RX_STOP;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: receives a framed, XOR-checksummed program image over UART and
// writes little-endian 32-bit words into instruction RAM, holding the core until verified.
module uart_imem_loader
   import loader_pkg::*;
#(
   parameter int         CLK_HZ      = 100_000_000,
   parameter int         BAUD        = 115200,
   parameter int         ADDR_W      = 8,
   parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
   parameter int         TIMEOUT_CYC = 1_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              uart_rx,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   localparam int BIT_CNT = bit_cnt_of(CLK_HZ, BAUD);
   localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   widx_q, widx_d;
   logic [1:0]        bidx_q, bidx_d;
   logic [31:0]       buf_q, buf_d;
   logic [7:0]        csum_q, csum_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic       rx_valid, rx_ferr;
   logic [7:0] rx_byte;
   logic       frame_s, timeout_s, sync_s;

   uart_rx_byte #(.BIT_CNT(BIT_CNT)) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .uart_rx  (uart_rx),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .rx_ferr  (rx_ferr)
   );

   assign im_we    = we_q;
   assign im_addr  = addr_q;
   assign im_wdata = wdata_q;
   assign cpu_hold = hold_q;
   assign done     = done_q;
   assign err      = err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_SYNC;
         len_q   <= '0;
         widx_q  <= '0;
         bidx_q  <= 2'd0;
         buf_q   <= 32'h0;
         csum_q  <= 8'h00;
         tmo_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         widx_q  <= widx_d;
         bidx_q  <= bidx_d;
         buf_q   <= buf_d;
         csum_q  <= csum_d;
         tmo_q   <= tmo_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      widx_d    = widx_q;
      bidx_d    = bidx_q;
      buf_d     = buf_q;
      csum_d    = csum_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      frame_s   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
      sync_s    = rx_valid && (rx_byte == SYNC_BYTE);
      tmo_d     = (frame_s && !rx_valid) ? tmo_q + TMO_W'(1) : '0;
      timeout_s = frame_s && !rx_valid && (tmo_q == TMO_LAST);
      case (state_q)
         S_SYNC, S_ERR: begin
            if (sync_s) begin
               state_d = S_LEN;
               csum_d  = 8'h00;
               widx_d  = '0;
               bidx_d  = 2'd0;
            end else begin
               state_d = state_q;
            end
         end
         S_LEN: begin
            if (rx_valid) begin
               // A zero length byte means a full memory image.
               len_d   = (rx_byte == 8'h00) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W + 1)'(rx_byte);
               state_d = S_DATA;
            end else begin
               state_d = S_LEN;
            end
         end
         S_DATA: begin
            if (rx_valid) begin
               buf_d  = {rx_byte, buf_q[31:8]};
               csum_d = csum_q ^ rx_byte;
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  we_d    = 1'b1;
                  addr_d  = widx_q[ADDR_W-1:0];
                  wdata_d = {rx_byte, buf_q[31:8]};
                  widx_d  = widx_q + (ADDR_W + 1)'(1);
               end else begin
                  we_d = 1'b0;
               end
            end else if (we_q && (widx_q == len_q)) begin
               // Leave only after the final strobe so im_we never overlaps S_CSUM.
               state_d = S_CSUM;
            end else begin
               state_d = S_DATA;
            end
         end
         S_CSUM: begin
            if (rx_valid) state_d = (rx_byte == csum_q) ? S_DONE : S_ERR;
            else          state_d = S_CSUM;
         end
         S_DONE:  state_d = S_DONE;
         default: state_d = S_SYNC;
      endcase
      if (frame_s && (rx_ferr || timeout_s)) begin
         state_d = S_ERR;
      end else begin
         state_d = state_d;
      end
      done_d = (state_d == S_DONE);
      hold_d = (state_d != S_DONE);
      err_d  = (state_d == S_ERR);
   end

endmodule
